// File: rtl/fpu_types_pkg.sv
// Shared types for the FP writeback path: accrued exception flags and the
// writeback arbiter priority state.
package fpu_types_pkg;

    // Exception flags, MSB first: invalid, divide-by-zero, overflow,
    // underflow, inexact.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int FFLAGS_W = $bits(fflags_t);
    localparam int RD_W     = 5;

    // Which requester wins when both are valid in the same cycle.
    typedef enum logic {
        PRIO_FPU = 1'b0,
        PRIO_LD  = 1'b1
    } prio_state_t;

    // Next accrued-flag value. A CSR write replaces the accumulator before
    // the flags of a simultaneous FPU writeback are ORed in, so those
    // exceptions are never lost.
    function automatic logic [FFLAGS_W-1:0] next_fflags(
        input logic [FFLAGS_W-1:0] cur,
        input logic                csr_we,
        input logic [FFLAGS_W-1:0] csr_wdata,
        input logic                fpu_xfer,
        input logic [FFLAGS_W-1:0] fpu_flags
    );
        logic [FFLAGS_W-1:0] base;
        base = csr_we ? csr_wdata : cur;
        return fpu_xfer ? (base | fpu_flags) : base;
    endfunction

endpackage

// File: rtl/f_wb_arbiter_if.sv
// Requester handshakes (FPU result, FLW load data) and the FP register-file
// write port. The arbiter uses the slave view; the producers and register
// file together form the master view.
interface f_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 5
);
    import fpu_types_pkg::*;

    logic              fpu_valid;
    logic              fpu_ready;
    logic [RD_W-1:0]   fpu_rd;
    logic [DATA_W-1:0] fpu_data;
    logic [FLAG_W-1:0] fpu_flags;

    logic              ld_valid;
    logic              ld_ready;
    logic [RD_W-1:0]   ld_rd;
    logic [DATA_W-1:0] ld_data;

    logic              f_wen;
    logic [RD_W-1:0]   f_rd;
    logic [DATA_W-1:0] f_w_data;

    modport slave (
        input  fpu_valid, fpu_rd, fpu_data, fpu_flags,
        input  ld_valid, ld_rd, ld_data,
        output fpu_ready, ld_ready,
        output f_wen, f_rd, f_w_data
    );

    modport master (
        output fpu_valid, fpu_rd, fpu_data, fpu_flags,
        output ld_valid, ld_rd, ld_data,
        input  fpu_ready, ld_ready,
        input  f_wen, f_rd, f_w_data
    );

endinterface

// File: rtl/f_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter for the FP writeback port.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   PRIO_FPU | FPU wins a simultaneous request (reset state)
//   PRIO_LD  | load wins a simultaneous request
//
// Grants are purely a function of the request lines, the priority state,
// stall and reset; no requester payload reaches this block, so ready can
// never loop back through data.
module rr_arb2
    import fpu_types_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic req_fpu,
    input  logic req_ld,
    output logic gnt_fpu,
    output logic gnt_ld
);

    prio_state_t state_q;
    prio_state_t state_d;
    logic        enable;

    // Reset also blocks grants so a request seen during reset is never
    // accepted and cannot leave a stale write behind.
    assign enable = rst_n & ~stall;

    // Priority state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PRIO_FPU;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decode and next priority: the loser of a grant gets priority,
    // an idle or stalled cycle keeps it.
    always_comb begin
        gnt_fpu = 1'b0;
        gnt_ld  = 1'b0;
        state_d = state_q;

        if (enable) begin
            unique case (state_q)
                PRIO_FPU: begin
                    if (req_fpu) begin
                        gnt_fpu = 1'b1;
                    end else if (req_ld) begin
                        gnt_ld = 1'b1;
                    end
                end
                PRIO_LD: begin
                    if (req_ld) begin
                        gnt_ld = 1'b1;
                    end else if (req_fpu) begin
                        gnt_fpu = 1'b1;
                    end
                end
                default: begin
                    gnt_fpu = 1'b0;
                    gnt_ld  = 1'b0;
                end
            endcase
        end

        if (gnt_fpu) begin
            state_d = PRIO_LD;
        end else if (gnt_ld) begin
            state_d = PRIO_FPU;
        end
    end

endmodule

// File: rtl/f_wb_arbiter.sv
// FP register-file writeback arbiter. Merges FPU results and FLW load data
// onto the single FP RF write port with one cycle of latency and accrues
// the FPU exception flags into fflags alongside CSR writes.
module f_wb_arbiter
    import fpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    f_wb_arbiter_if.slave     bus,
    input  logic              wb_stall,
    input  logic              csr_fflags_we,
    input  logic [FLAG_W-1:0] csr_fflags_wdata,
    output logic [FLAG_W-1:0] fflags
);

    logic              gnt_fpu;
    logic              gnt_ld;
    logic              xfer_fpu;
    logic              xfer_ld;

    logic              wen_q;
    logic [RD_W-1:0]   rd_q;
    logic [DATA_W-1:0] data_q;
    logic [RD_W-1:0]   rd_d;
    logic [DATA_W-1:0] data_d;
    logic [FLAG_W-1:0] fflags_q;
    logic [FLAG_W-1:0] fflags_d;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst_n   (nRST),
        .stall   (wb_stall),
        .req_fpu (bus.fpu_valid),
        .req_ld  (bus.ld_valid),
        .gnt_fpu (gnt_fpu),
        .gnt_ld  (gnt_ld)
    );

    // A grant is only ever issued to a valid requester, so the grant is
    // both the ready and the transfer qualifier.
    assign bus.fpu_ready = gnt_fpu;
    assign bus.ld_ready  = gnt_ld;
    assign xfer_fpu      = bus.fpu_valid & gnt_fpu;
    assign xfer_ld       = bus.ld_valid  & gnt_ld;

    // Select the winning payload; without a transfer the write port keeps
    // its last address and data.
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        if (xfer_fpu) begin
            rd_d   = bus.fpu_rd;
            data_d = bus.fpu_data;
        end else if (xfer_ld) begin
            rd_d   = bus.ld_rd;
            data_d = bus.ld_data;
        end
    end

    // Flag accrual: CSR write replaces, FPU writeback ORs on top.
    always_comb begin
        fflags_d = fflags_q;
        if (FLAG_W == FFLAGS_W) begin
            fflags_d = next_fflags(fflags_q, csr_fflags_we, csr_fflags_wdata,
                                   xfer_fpu, bus.fpu_flags);
        end else begin
            if (csr_fflags_we) begin
                fflags_d = csr_fflags_wdata;
            end
            if (xfer_fpu) begin
                fflags_d = fflags_d | bus.fpu_flags;
            end
        end
    end

    // Writeback register and flag accumulator.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wen_q    <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            fflags_q <= '0;
        end else begin
            wen_q    <= xfer_fpu | xfer_ld;
            rd_q     <= rd_d;
            data_q   <= data_d;
            fflags_q <= fflags_d;
        end
    end

    assign bus.f_wen    = wen_q;
    assign bus.f_rd     = rd_q;
    assign bus.f_w_data = data_q;
    assign fflags       = fflags_q;

endmodule
